cpu_fetch_queue: RTL and testbench

Parametrised successor to the single-PC fetch stage. Streams sequential fetch requests to instruction memory with up to DEPTH requests outstanding, buffers returned instructions with their PCs in a FIFO, and hands them to decode over a valid/ready handshake. A taken branch reported by commit redirects the PC, flushes the FIFO and squashes all in-flight responses.

---
 rtl/cpu_fetch_queue_if.sv | 31 +++
 rtl/cpu_fetch_queue.sv | 107 ++++++++++
 tb/tb_cpu_fetch_queue.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response and decode handshake.
// The master modport is the fetch queue; the slave modport is memory plus decode.
interface cpu_fetch_queue_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               decode_valid;
  logic               decode_ready;
  logic [INSTR_W-1:0] decode_instr;
  logic [XLEN-1:0]    decode_pc;
  logic [XLEN-1:0]    decode_next_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output decode_valid, decode_instr, decode_pc, decode_next_pc,
    input  decode_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  decode_valid, decode_instr, decode_pc, decode_next_pc,
    output decode_ready
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// Pipelined instruction fetch: up to DEPTH requests in flight, in-order response FIFO
// feeding decode, and branch redirect that flushes the FIFO and drops stale responses.
module cpu_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_branch,
  input  logic             commit_zero,
  input  logic [XLEN-1:0]  commit_target,
  output logic [XLEN-1:0]  fetch_pc,
  cpu_fetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0]    pc;
  logic [CW-1:0]      occ;
  logic [CW-1:0]      outst;
  logic [CW-1:0]      drop;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      aq_wr;
  logic [AW-1:0]      aq_rd;

  logic [INSTR_W-1:0] fifo_instr [DEPTH];
  logic [XLEN-1:0]    fifo_pc    [DEPTH];
  logic [XLEN-1:0]    aq_mem     [DEPTH];

  logic               redirect_c;
  logic [CW:0]        in_use_c;
  logic               issue_c;
  logic               accept_c;
  logic               discard_c;
  logic               take_c;
  logic               push_c;
  logic               pop_c;

  // Request gating counts FIFO entries plus in-flight requests so every response has a slot.
  always_comb begin
    redirect_c = commit_branch & commit_zero;
    in_use_c   = {1'b0, occ} + {1'b0, outst};
    issue_c    = reset & (in_use_c < (CW+1)'(DEPTH)) & ~redirect_c;
    accept_c   = issue_c & bus.imem_req_ready;
    discard_c  = bus.imem_resp_valid & (drop != '0);
    take_c     = bus.imem_resp_valid & (drop == '0);
    push_c     = reset & take_c & ~redirect_c;
    pop_c      = (occ != '0) & bus.decode_ready;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc     <= RESET_PC;
      occ    <= '0;
      outst  <= '0;
      drop   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      aq_wr  <= '0;
      aq_rd  <= '0;
    end else if (redirect_c) begin
      // A live response arriving now belongs to the old path: discard it rather than drop later.
      pc     <= commit_target;
      occ    <= '0;
      outst  <= '0;
      drop   <= drop - CW'(discard_c) + outst - CW'(take_c);
      wr_ptr <= '0;
      rd_ptr <= '0;
      aq_wr  <= '0;
      aq_rd  <= '0;
    end else begin
      if (accept_c) begin
        pc    <= pc + XLEN'(PC_STEP);
        aq_wr <= aq_wr + AW'(1);
      end
      if (take_c) aq_rd <= aq_rd + AW'(1);
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c) rd_ptr <= rd_ptr + AW'(1);
      outst <= outst + CW'(accept_c) - CW'(take_c);
      drop  <= drop - CW'(discard_c);
      occ   <= occ + CW'(push_c) - CW'(pop_c);
    end
  end

  // Payload storage needs no reset; validity is tracked by the counters above.
  always_ff @(posedge clock) begin
    if (accept_c) aq_mem[aq_wr] <= pc;
    if (push_c) begin
      fifo_instr[wr_ptr] <= bus.imem_resp_data;
      fifo_pc[wr_ptr]    <= aq_mem[aq_rd];
    end
  end

  assign bus.imem_req_valid = issue_c;
  assign bus.imem_req_addr  = pc;
  assign bus.decode_valid   = (occ != '0);
  assign bus.decode_instr   = fifo_instr[rd_ptr];
  assign bus.decode_pc      = fifo_pc[rd_ptr];
  assign bus.decode_next_pc = fifo_pc[rd_ptr] + XLEN'(PC_STEP);
  assign fetch_pc           = pc;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: vector table for streaming/backpressure,
// hand sequences for redirects, drops and a wrapping RESET_PC instance.
module tb_cpu_fetch_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        rst2;
  logic        br;
  logic        zero;
  logic [31:0] tgt;
  logic [31:0] fpc;
  logic [31:0] fpc2;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  int          cyc      = 0;
  int          acc      = 0;
  logic [31:0] dlog  [$];
  logic [31:0] dlog2 [$];

  typedef struct {
    logic [31:0] addr;
    int          t;
  } mreq_t;
  mreq_t mq [$];

  typedef struct {
    logic        rst;
    logic        dr;
    logic        dv;
    logic [31:0] dpc;
    logic        rv;
    logic [31:0] fpc;
    int          acc;
  } vec_t;
  vec_t vt [25];

  cpu_fetch_queue_if #(.XLEN(32), .INSTR_W(32)) bus ();
  cpu_fetch_queue_if #(.XLEN(32), .INSTR_W(32)) bus2 ();

  cpu_fetch_queue #(.XLEN(32), .INSTR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .commit_branch(br), .commit_zero(zero),
    .commit_target(tgt), .fetch_pc(fpc), .bus(bus)
  );

  cpu_fetch_queue #(.XLEN(32), .INSTR_W(32), .DEPTH(4), .PC_STEP(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clock(clock), .reset(rst2), .commit_branch(1'b0), .commit_zero(1'b0),
    .commit_target(32'h0), .fetch_pc(fpc2), .bus(bus2)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory model for dut: in-order responses mem_lat cycles after acceptance; monitors.
  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      mq.delete();
      acc = 0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq.push_back('{bus.imem_req_addr, cyc});
        acc++;
      end
      if (bus.decode_valid && bus.decode_ready) dlog.push_back(bus.decode_pc);
    end
    if (rst2 && bus2.decode_valid && bus2.decode_ready) dlog2.push_back(bus2.decode_pc);
  end

  always @(negedge clock) begin
    if (mq.size() > 0 && (mq[0].t + mem_lat - 1 <= cyc)) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = instr_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
    end
  end

  // Single-cycle memory for dut2.
  logic        m2_valid;
  logic [31:0] m2_addr;
  always @(posedge clock) begin
    m2_valid <= rst2 && bus2.imem_req_valid && bus2.imem_req_ready;
    m2_addr  <= bus2.imem_req_addr;
  end
  assign bus2.imem_resp_valid = m2_valid;
  assign bus2.imem_resp_data  = instr_of(m2_addr);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    br    = 1'b0;
    zero  = 1'b0;
    tgt   = 32'h0;
    repeat (2) nxt();
    dlog.delete();
  endtask

  task automatic wait_dv(input string nm);
    int n = 0;
    while (!bus.decode_valid && n < 30) begin
      nxt();
      #1;
      n++;
    end
    check(nm, 32'(bus.decode_valid), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rst, dr, dv, dpc, rv, fpc, accepts since reset
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00, 0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04, 1};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b1, 32'h08, 2};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0C, 3};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h10, 4};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h14, 5};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h18, 6};
    vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h1C, 7};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b0, 32'h20, 8};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00, 0};
    vt[11] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h04, 1};
    vt[12] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 32'h08, 2};
    vt[13] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b1, 32'h0C, 3};
    for (int i = 14; i < 20; i++) vt[i] = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h10, 4};
    vt[20] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h10, 4};
    vt[21] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h10, 4};
    vt[22] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h14, 5};
    vt[23] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h18, 6};
    vt[24] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1C, 7};

    reset = 1'b0;
    rst2  = 1'b0;
    br    = 1'b0;
    zero  = 1'b0;
    tgt   = 32'h0;
    bus.imem_req_ready  = 1'b1;
    bus.decode_ready    = 1'b1;
    bus2.imem_req_ready = 1'b1;
    bus2.decode_ready   = 1'b1;
    repeat (3) nxt();

    // Streaming, mid-stream reset, then decode backpressure and drain.
    for (int i = 0; i < 25; i++) begin
      nxt();
      reset = vt[i].rst;
      bus.decode_ready = vt[i].dr;
      #1;
      check($sformatf("v%0d_dv", i), 32'(bus.decode_valid), 32'(vt[i].dv));
      check($sformatf("v%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vt[i].rv));
      check($sformatf("v%0d_fetch_pc", i), fpc, vt[i].fpc);
      check($sformatf("v%0d_req_addr", i), bus.imem_req_addr, vt[i].fpc);
      check($sformatf("v%0d_accepts", i), 32'(acc), 32'(vt[i].acc));
      if (vt[i].dv) begin
        check($sformatf("v%0d_dpc", i), bus.decode_pc, vt[i].dpc);
        check($sformatf("v%0d_next_pc", i), bus.decode_next_pc, vt[i].dpc + 32'd4);
        check($sformatf("v%0d_instr", i), bus.decode_instr, instr_of(vt[i].dpc));
      end
    end

    // Two stale responses in flight at redirect to 0x100.
    do_reset();
    mem_lat = 3;
    bus.decode_ready = 1'b1;
    nxt(); reset = 1'b1;
    nxt();
    nxt(); br = 1'b1; zero = 1'b1; tgt = 32'h100;
    #1;
    check("t3_redirect_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t3_outstanding_accepts", 32'(acc), 32'd2);
    nxt(); br = 1'b0; zero = 1'b0;
    #1;
    check("t3_fetch_pc", fpc, 32'h100);
    check("t3_req_addr", bus.imem_req_addr, 32'h100);
    check("t3_fifo_empty", 32'(bus.decode_valid), 32'd0);
    wait_dv("t3_dv_timeout");
    check("t3_first_pc", bus.decode_pc, 32'h100);
    check("t3_first_instr", bus.decode_instr, instr_of(32'h100));
    check("t3_nothing_stale", 32'(dlog.size()), 32'd0);

    // Redirect with a live response and a decode pop in the same cycle.
    do_reset();
    mem_lat = 1;
    bus.decode_ready = 1'b0;
    nxt(); reset = 1'b1;
    nxt();
    nxt(); bus.decode_ready = 1'b1; br = 1'b1; zero = 1'b1; tgt = 32'h400;
    #1;
    check("t4_head_valid", 32'(bus.decode_valid), 32'd1);
    check("t4_head_pc", bus.decode_pc, 32'h0);
    check("t4_req_valid", 32'(bus.imem_req_valid), 32'd0);
    nxt(); br = 1'b0; zero = 1'b0;
    #1;
    check("t4_pop_count", 32'(dlog.size()), 32'd1);
    check("t4_pop_pc", (dlog.size() > 0) ? dlog[0] : 32'hDEAD_BEEF, 32'h0);
    check("t4_req_valid_after", 32'(bus.imem_req_valid), 32'd1);
    check("t4_req_addr", bus.imem_req_addr, 32'h400);
    check("t4_flushed", 32'(bus.decode_valid), 32'd0);
    wait_dv("t4_dv_timeout");
    check("t4_first_new_pc", bus.decode_pc, 32'h400);
    check("t4_no_extra_pop", 32'(dlog.size()), 32'd1);

    // Back-to-back redirects with three requests outstanding.
    do_reset();
    mem_lat = 4;
    bus.decode_ready = 1'b1;
    nxt(); reset = 1'b1;
    nxt();
    nxt();
    nxt(); br = 1'b1; zero = 1'b1; tgt = 32'h200;
    #1;
    check("t5_outstanding", 32'(acc), 32'd3);
    check("t5_req_valid_r1", 32'(bus.imem_req_valid), 32'd0);
    nxt(); tgt = 32'h300;
    #1;
    check("t5_fetch_pc_r1", fpc, 32'h200);
    check("t5_req_valid_r2", 32'(bus.imem_req_valid), 32'd0);
    nxt(); br = 1'b0; zero = 1'b0;
    #1;
    check("t5_fetch_pc_r2", fpc, 32'h300);
    check("t5_req_addr", bus.imem_req_addr, 32'h300);
    wait_dv("t5_dv_timeout");
    check("t5_first_pc", bus.decode_pc, 32'h300);
    check("t5_nothing_stale", 32'(dlog.size()), 32'd0);
    nxt();
    #1;
    check("t5_second_valid", 32'(bus.decode_valid), 32'd1);
    check("t5_second_pc", bus.decode_pc, 32'h304);

    // Wrapping RESET_PC instance and reset asserted mid-stream.
    nxt(); rst2 = 1'b1;
    #1;
    check("t6_c0_fetch_pc", fpc2, 32'hFFFF_FFF8);
    check("t6_c0_req_valid", 32'(bus2.imem_req_valid), 32'd1);
    nxt();
    #1;
    check("t6_c1_fetch_pc", fpc2, 32'hFFFF_FFFC);
    nxt();
    #1;
    check("t6_c2_fetch_wrap", fpc2, 32'h0);
    check("t6_c2_dpc", bus2.decode_pc, 32'hFFFF_FFF8);
    check("t6_c2_next_pc", bus2.decode_next_pc, 32'hFFFF_FFFC);
    nxt();
    #1;
    check("t6_c3_dpc", bus2.decode_pc, 32'hFFFF_FFFC);
    check("t6_c3_next_wrap", bus2.decode_next_pc, 32'h0);
    nxt();
    #1;
    check("t6_c4_dpc", bus2.decode_pc, 32'h0);
    check("t6_c4_instr", bus2.decode_instr, instr_of(32'h0));
    nxt(); rst2 = 1'b0;
    #1;
    check("t6_c5_req_valid", 32'(bus2.imem_req_valid), 32'd0);
    nxt();
    #1;
    check("t6_c6_dv_after_reset", 32'(bus2.decode_valid), 32'd0);
    check("t6_c6_fetch_pc", fpc2, 32'hFFFF_FFF8);
    nxt(); rst2 = 1'b1;
    dlog2.delete();
    #1;
    check("t6_c7_req_addr", bus2.imem_req_addr, 32'hFFFF_FFF8);
    check("t6_c7_dv", 32'(bus2.decode_valid), 32'd0);
    nxt();
    nxt();
    #1;
    check("t6_c9_dv", 32'(bus2.decode_valid), 32'd1);
    check("t6_c9_dpc", bus2.decode_pc, 32'hFFFF_FFF8);
    check("t6_no_pop_before", 32'(dlog2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
